// File: rtl/ad7768_pkg.sv
// Shared widths, FSM state encoding and FIFO entry layout for the AD7768 data receiver.
package ad7768_pkg;
  localparam int HDR_W  = 8;
  localparam int DATA_W = 24;
  localparam int WORD_W = HDR_W + DATA_W;
  localparam int CHAN_W = 8;

  typedef enum logic [1:0] {IDLE, WAIT_DRDY, SHIFT} state_t;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [HDR_W-1:0]  hdr;
    logic [DATA_W-1:0] data;
  } entry_t;
endpackage

// File: rtl/ad7768_rx_fifo.sv
// Single-clock FIFO with a registered head; a push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module ad7768_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic         sclk,
  input  logic         srst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic         o_valid,
  output logic         o_full,
  output logic [W-1:0] o_head,
  output logic         o_drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr, w_rptr_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_valid;
  logic [W-1:0]  r_head, w_head_nxt;
  logic          w_pop, w_wr;

  assign w_pop       = i_pop && r_valid;
  assign o_full      = (r_count == (AW+1)'(DEPTH));
  assign w_wr        = i_push && (!o_full || w_pop);
  assign o_drop      = i_push && o_full && !w_pop;
  assign w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;
  assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);
  // Bypass the write data when it lands exactly where the next head will be read.
  assign w_head_nxt  = (w_wr && (r_wptr == w_rptr_nxt)) ? i_wdata : r_mem[w_rptr_nxt];

  always_ff @(posedge sclk) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_valid <= 1'b0;
      r_head  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) r_head <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_head  = r_head;
endmodule

// File: rtl/ad7768_data_rx.sv
// AD7768 conversion-data receiver: synchronizes DCLK/DRDY/DOUT, deserializes 32-bit words per lane
// and streams them out tagged by channel. Optional header check: define AD7768_HDR_CHECK_EN.
//   state     | meaning
//   IDLE      | not armed, waiting for cfg_done
//   WAIT_DRDY | armed, waiting for a frame start
//   SHIFT     | deserializing a frame
module ad7768_data_rx
  import ad7768_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int CH_PER_LANE = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                                    sclk,
  input  logic                                    srst_n,
  input  logic                                    cfg_done,
  input  logic                                    clr_status,
  input  logic                                    dclk,
  input  logic                                    drdy,
  input  logic [NUM_LANES-1:0]                    dout,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [$clog2(NUM_LANES*CH_PER_LANE)-1:0] out_chan,
  output logic [HDR_W-1:0]                        out_hdr,
  output logic [DATA_W-1:0]                       out_data,
  output logic                                    ovf,
  output logic                                    frame_err,
  output logic                                    hdr_err
);
  localparam int CH_W   = $clog2(NUM_LANES*CH_PER_LANE);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int WC_W   = (CH_PER_LANE > 1) ? $clog2(CH_PER_LANE) : 1;
  localparam logic [WC_W-1:0]   LAST_WC   = WC_W'(CH_PER_LANE-1);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES-1);

  logic [2:0]           r_dclk_sync;
  logic [1:0]           r_drdy_sync;
  logic [NUM_LANES-1:0] r_dout_s1, r_dout_s2;
  logic                 w_fe, w_drdy;

  state_t            r_state, w_state_nxt;
  logic              w_start, w_shift, w_resync, w_word_done;
  logic [4:0]        r_bit_cnt;
  logic [WC_W-1:0]   r_word_cnt, r_drain_wc;
  logic [WORD_W-2:0] r_sr   [NUM_LANES];
  logic [WORD_W-1:0] r_bank [NUM_LANES];
  logic              r_drain_act;
  logic [LANE_W-1:0] r_drain_lane;

  entry_t                     w_push_ent, w_head;
  logic [$bits(entry_t)-1:0]  w_head_bits;
  logic                       w_drop, w_unused_full, w_unused_chan;
  logic                       r_ovf, r_frame_err;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_dclk_sync <= '0;
      r_drdy_sync <= '0;
      r_dout_s1   <= '0;
      r_dout_s2   <= '0;
    end else begin
      r_dclk_sync <= {r_dclk_sync[1:0], dclk};
      r_drdy_sync <= {r_drdy_sync[0], drdy};
      r_dout_s1   <= dout;
      r_dout_s2   <= r_dout_s1;
    end
  end

  // dout_s2 shares the sync depth of dclk_sync[1], so it holds the bit present at the falling edge.
  assign w_fe   = r_dclk_sync[2] & ~r_dclk_sync[1];
  assign w_drdy = r_drdy_sync[1];

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift     = 1'b0;
    w_resync    = 1'b0;
    if (cfg_done) begin
      w_state_nxt = WAIT_DRDY;
    end else begin
      case (r_state)
        IDLE: ;
        WAIT_DRDY: begin
          if (w_fe && w_drdy) begin
            w_start     = 1'b1;
            w_state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (w_fe) begin
            if (w_drdy && ((r_bit_cnt != 5'd31) || (r_word_cnt != '0))) begin
              w_resync = 1'b1;
              w_start  = 1'b1;
            end else begin
              w_shift = 1'b1;
              if ((r_bit_cnt == 5'd0) && (r_word_cnt == LAST_WC)) w_state_nxt = WAIT_DRDY;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_word_done = w_shift && (r_bit_cnt == 5'd0);

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_bit_cnt  <= '0;
      r_word_cnt <= '0;
      r_drain_wc <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_sr[l]   <= '0;
        r_bank[l] <= '0;
      end
    end else if (w_start) begin
      r_bit_cnt  <= 5'd30;
      r_word_cnt <= '0;
      for (int l = 0; l < NUM_LANES; l++) r_sr[l] <= {{(WORD_W-2){1'b0}}, r_dout_s2[l]};
    end else if (w_shift) begin
      for (int l = 0; l < NUM_LANES; l++) r_sr[l] <= {r_sr[l][WORD_W-3:0], r_dout_s2[l]};
      if (r_bit_cnt == 5'd0) begin
        for (int l = 0; l < NUM_LANES; l++) r_bank[l] <= {r_sr[l], r_dout_s2[l]};
        r_drain_wc <= r_word_cnt;
        r_bit_cnt  <= 5'd31;
        r_word_cnt <= r_word_cnt + WC_W'(1);
      end else begin
        r_bit_cnt <= r_bit_cnt - 5'd1;
      end
    end
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_drain_act  <= 1'b0;
      r_drain_lane <= '0;
    end else if (w_word_done) begin
      r_drain_act  <= 1'b1;
      r_drain_lane <= '0;
    end else if (r_drain_act) begin
      if (r_drain_lane == LAST_LANE) r_drain_act <= 1'b0;
      else                           r_drain_lane <= r_drain_lane + LANE_W'(1);
    end
  end

  always_comb begin
    w_push_ent      = '0;
    w_push_ent.chan = CHAN_W'(r_drain_lane) * CHAN_W'(CH_PER_LANE) + CHAN_W'(r_drain_wc);
    w_push_ent.hdr  = r_bank[r_drain_lane][WORD_W-1:DATA_W];
    w_push_ent.data = r_bank[r_drain_lane][DATA_W-1:0];
  end

  ad7768_rx_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(entry_t))) u_fifo (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .i_push  (r_drain_act),
    .i_wdata (w_push_ent),
    .i_pop   (out_valid && out_ready),
    .o_valid (out_valid),
    .o_full  (w_unused_full),
    .o_head  (w_head_bits),
    .o_drop  (w_drop)
  );

  assign w_head        = entry_t'(w_head_bits);
  assign out_chan      = w_head.chan[CH_W-1:0];
  assign out_hdr       = w_head.hdr;
  assign out_data      = w_head.data;
  assign w_unused_chan = ^w_head.chan[CHAN_W-1:CH_W];

  // Sticky flags: a set in the same cycle as clr_status wins.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)          r_ovf <= 1'b1;
      else if (clr_status) r_ovf <= 1'b0;
      if (w_resync)        r_frame_err <= 1'b1;
      else if (clr_status) r_frame_err <= 1'b0;
    end
  end

  assign ovf       = r_ovf;
  assign frame_err = r_frame_err;

`ifdef AD7768_HDR_CHECK_EN
  logic w_hdr_bad, r_hdr_err;

  assign w_hdr_bad = r_drain_act &&
                     (w_push_ent.hdr[7] || (w_push_ent.hdr[6:4] != w_push_ent.chan[2:0]));

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n)         r_hdr_err <= 1'b0;
    else if (w_hdr_bad)  r_hdr_err <= 1'b1;
    else if (clr_status) r_hdr_err <= 1'b0;
  end

  assign hdr_err = r_hdr_err;
`else
  assign hdr_err = 1'b0;
`endif
endmodule

// File: tb/tb_ad7768_data_rx.sv
// Scoreboard bench for ad7768_data_rx: directed frames push expected words, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ad7768_data_rx;
  import ad7768_pkg::*;

  localparam int NL  = 2;
  localparam int CPL = 4;

  logic          sclk = 1'b0, srst_n = 1'b0, cfg_done = 1'b0, clr_status = 1'b0;
  logic          dclk = 1'b0, drdy = 1'b0, out_ready = 1'b0;
  logic [NL-1:0] dout = '0;
  logic          out_valid, ovf, frame_err, hdr_err;
  logic [2:0]    out_chan;
  logic [7:0]    out_hdr;
  logic [23:0]   out_data;

  ad7768_data_rx #(.NUM_LANES(NL), .CH_PER_LANE(CPL), .FIFO_DEPTH(8)) dut (
    .sclk(sclk), .srst_n(srst_n), .cfg_done(cfg_done), .clr_status(clr_status),
    .dclk(dclk), .drdy(drdy), .dout(dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
    .out_hdr(out_hdr), .out_data(out_data),
    .ovf(ovf), .frame_err(frame_err), .hdr_err(hdr_err)
  );

  always #5 sclk = ~sclk;

  typedef struct packed {
    logic [2:0]  chan;
    logic [7:0]  hdr;
    logic [23:0] data;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_err = 0;
  int   g_exp_left = 0;
  int   g_bad_chan = -1;

  // Hand-picked words per global channel; headers carry chan in [6:4].
  logic [31:0] tbl [8] = '{32'h00123456, 32'h10ABCDEF, 32'h20800000, 32'h307FFFFF,
                           32'h40000001, 32'h50FFFFFF, 32'h60555555, 32'h70AAAAAA};

  function automatic logic [31:0] word_of(input int ch, input int v);
    logic [31:0] w;
    w = tbl[ch];
    w[23:0] = w[23:0] ^ (24'(v) * 24'h111111);
    if (ch == g_bad_chan) w[31:24] = 8'h80;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  task automatic pulse_cfg();
    @(posedge sclk); #1 cfg_done = 1'b1;
    @(posedge sclk); #1 cfg_done = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge sclk); #1 clr_status = 1'b1;
    @(posedge sclk); #1 clr_status = 1'b0;
  endtask

  // DCLK = sclk/8; data changes on DCLK rise and is sampled on its fall.
  task automatic send_frame(input int v, input int abort_w, input int abort_b);
    logic [31:0] wd [NL];
    exp_t e;
    for (int w = 0; w < CPL; w++) begin
      for (int l = 0; l < NL; l++) begin
        wd[l] = word_of(l*CPL + w, v);
        if (w != abort_w && g_exp_left > 0) begin
          e.chan = 3'(l*CPL + w);
          e.hdr  = wd[l][31:24];
          e.data = wd[l][23:0];
          q.push_back(e);
          g_exp_left--;
        end
      end
      for (int b = 31; b >= 0; b--) begin
        if (w == abort_w && b == abort_b) return;
        dclk = 1'b1;
        drdy = (w == 0 && b == 31);
        for (int l = 0; l < NL; l++) dout[l] = wd[l][b];
        #40 dclk = 1'b0;
        #40;
      end
    end
    repeat (2) begin
      dclk = 1'b1; drdy = 1'b0; dout = '0;
      #40 dclk = 1'b0;
      #40;
    end
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (q.size() != 0 && k < 3000) begin
      @(posedge sclk);
      k++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d words still expected after %0d cycles", nm, q.size(), k);
      q.delete();
    end
    tick(20);
  endtask

  logic held = 1'b0;
  exp_t prev;
  always @(negedge sclk) begin
    exp_t e;
    if (srst_n && held) begin
      n_cmp++;
      if (!out_valid || {out_chan, out_hdr, out_data} !== prev) begin
        n_err++;
        $display("FAIL hold: got v=%0b %0h expected v=1 %0h", out_valid, {out_chan, out_hdr, out_data}, prev);
      end
    end
    if (srst_n && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got chan=%0d hdr=%0h data=%0h expected none",
                 out_chan, out_hdr, out_data);
      end else begin
        e = q.pop_front();
        if ({out_chan, out_hdr, out_data} !== e) begin
          n_err++;
          $display("FAIL word: got chan=%0d hdr=%0h data=%0h expected chan=%0d hdr=%0h data=%0h",
                   out_chan, out_hdr, out_data, e.chan, e.hdr, e.data);
        end
      end
    end
    held = srst_n && out_valid && !out_ready;
    prev = {out_chan, out_hdr, out_data};
  end

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_out_valid"}, 32'(out_valid), 0);
    chk({pfx, "_out_chan"},  32'(out_chan),  0);
    chk({pfx, "_out_hdr"},   32'(out_hdr),   0);
    chk({pfx, "_out_data"},  32'(out_data),  0);
    chk({pfx, "_ovf"},       32'(ovf),       0);
    chk({pfx, "_frame_err"}, 32'(frame_err), 0);
    chk({pfx, "_hdr_err"},   32'(hdr_err),   0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(5);
    chk_reset_vals("reset");
    srst_n = 1'b1;
    tick(5);

    // Frames before cfg_done are ignored.
    out_ready  = 1'b1;
    g_exp_left = 0;
    send_frame(0, -1, 0);
    tick(10);
    chk("unarmed_valid", 32'(out_valid), 0);

    // Normal capture, two data patterns.
    pulse_cfg();
    g_exp_left = 1000;
    send_frame(0, -1, 0);
    wait_drain("normal0");
    send_frame(1, -1, 0);
    wait_drain("normal1");
    chk("normal_ovf", 32'(ovf), 0);
    chk("normal_frame_err", 32'(frame_err), 0);

    // Backpressure: only the first 8 of 16 words survive.
    out_ready  = 1'b0;
    g_exp_left = 8;
    send_frame(2, -1, 0);
    send_frame(3, -1, 0);
    tick(10);
    chk("bp_ovf", 32'(ovf), 1);
    chk("bp_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_drain("bp");
    g_exp_left = 1000;
    pulse_clr();
    chk("clr_ovf", 32'(ovf), 0);

    // Resync: DRDY at bit 12 of word 2 restarts the frame.
    send_frame(4, 2, 12);
    send_frame(5, -1, 0);
    wait_drain("resync");
    chk("resync_frame_err", 32'(frame_err), 1);

    // Bad header on lane 1 word 0.
    g_bad_chan = 4;
    send_frame(6, -1, 0);
    wait_drain("hdr");
    g_bad_chan = -1;
`ifdef AD7768_HDR_CHECK_EN
    chk("hdr_err_set", 32'(hdr_err), 1);
`else
    chk("hdr_err_tied", 32'(hdr_err), 0);
`endif
    pulse_clr();
    chk("clr_hdr_err", 32'(hdr_err), 0);
    chk("clr_frame_err", 32'(frame_err), 0);

    // Reset in the middle of word 1 with lane words waiting in the FIFO.
    out_ready  = 1'b0;
    g_exp_left = 0;
    send_frame(7, 1, 20);
    chk("pre_rst_valid", 32'(out_valid), 1);
    srst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick(3);
    srst_n    = 1'b1;
    out_ready = 1'b1;
    tick(3);
    send_frame(0, -1, 0);
    tick(10);
    chk("post_rst_unarmed", 32'(out_valid), 0);
    pulse_cfg();
    g_exp_left = 1000;
    send_frame(1, -1, 0);
    wait_drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
